// File: rtl/tile_scheduler_if.sv
// Host command, tile-processor and status signals of tile_scheduler, bundled with
// slave (scheduler side) and master (host/environment side) modports.
interface tile_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_i0;
  logic [2:0]  cmd_j0;
  logic [2:0]  cmd_i1;
  logic [2:0]  cmd_j1;
  logic        abort;
  logic        tp_start;
  logic [2:0]  tp_op_code;
  logic [2:0]  tp_tile_i;
  logic [2:0]  tp_tile_j;
  logic        tp_done;
  logic        busy;
  logic        job_done;
  logic [1:0]  job_err;
  logic [6:0]  tiles_done;
  logic [31:0] perf_busy_cycles;

  modport slave (
    input  cmd_valid, cmd_op, cmd_i0, cmd_j0, cmd_i1, cmd_j1, abort, tp_done,
    output cmd_ready, tp_start, tp_op_code, tp_tile_i, tp_tile_j,
           busy, job_done, job_err, tiles_done, perf_busy_cycles
  );

  modport master (
    output cmd_valid, cmd_op, cmd_i0, cmd_j0, cmd_i1, cmd_j1, abort, tp_done,
    input  cmd_ready, tp_start, tp_op_code, tp_tile_i, tp_tile_j,
           busy, job_done, job_err, tiles_done, perf_busy_cycles
  );
endinterface

// File: rtl/tile_scheduler.sv
// Queues tile-range commands and walks each range row-major, one tile-processor start per tile.
// Latency: push to tp_start 3 edges; tp_done rising edge to next tp_start 2 edges.
// Backpressure: cmd_ready low while the command FIFO is full; TILE_SCHED_PERF_EN adds a busy-cycle counter.
module tile_scheduler #(
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  tile_scheduler_if.slave bus
);
  localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] i0;
    logic [2:0] j0;
    logic [2:0] i1;
    logic [2:0] j1;
  } cmd_t;

  cmd_t              r_mem [CMD_DEPTH];
  cmd_t              r_job;
  cmd_t              w_cmd_in;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FCNT_W-1:0] r_count;
  logic [FCNT_W-1:0] w_count_nxt;
  logic              r_cmd_ready;
  logic              w_push;
  logic              w_pop;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_done_d;
  logic              w_done_edge;
  logic              w_bad_cmd;
  logic              w_last_tile;
  logic              w_timeout;
  logic [CNT_W-1:0]  r_tmo_cnt;
  logic              r_tp_start;
  logic [2:0]        r_tp_op_code;
  logic [2:0]        r_tp_tile_i;
  logic [2:0]        r_tp_tile_j;
  logic              r_busy;
  logic              r_job_done;
  logic [1:0]        r_job_err;
  logic [6:0]        r_tiles_done;

  assign w_cmd_in    = {bus.cmd_op, bus.cmd_i0, bus.cmd_j0, bus.cmd_i1, bus.cmd_j1};
  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign w_push      = bus.cmd_valid && r_cmd_ready && !bus.abort;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && !bus.abort;
  assign w_done_edge = bus.tp_done && !r_done_d;
  assign w_bad_cmd   = (r_job.op > 3'd4) || (r_job.i1 < r_job.i0) || (r_job.j1 < r_job.j0);
  assign w_last_tile = (r_tp_tile_i == r_job.i1) && (r_tp_tile_j == r_job.j1);
  assign w_timeout   = (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_count_nxt = r_count;
    if (bus.abort) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = r_count + FCNT_W'(w_push) - FCNT_W'(w_pop);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_count != '0) w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = w_bad_cmd ? S_REPORT : S_ISSUE;
      S_ISSUE:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_done_edge)    w_state_nxt = S_NEXT;
        else if (w_timeout) w_state_nxt = S_REPORT;
      end
      S_NEXT:   w_state_nxt = w_last_tile ? S_REPORT : S_ISSUE;
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (bus.abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cmd_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_cmd_ready  <= 1'b1;
      r_state      <= S_IDLE;
      r_done_d     <= 1'b0;
      r_job        <= '0;
      r_tmo_cnt    <= '0;
      r_tp_start   <= 1'b0;
      r_tp_op_code <= 3'd0;
      r_tp_tile_i  <= 3'd0;
      r_tp_tile_j  <= 3'd0;
      r_busy       <= 1'b0;
      r_job_done   <= 1'b0;
      r_job_err    <= 2'd0;
      r_tiles_done <= 7'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_done_d    <= bus.tp_done;
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != FCNT_W'(CMD_DEPTH));
      r_busy      <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      // Outputs are registered from the next state so they line up with the state they describe.
      r_tp_start  <= (w_state_nxt == S_ISSUE);
      r_job_done  <= (w_state_nxt == S_REPORT);
      if (bus.abort) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case (r_state)
          S_IDLE: begin
            if (w_pop) begin
              r_job        <= r_mem[r_rd_ptr];
              r_tiles_done <= 7'd0;
            end
          end
          S_CHECK: begin
            if (w_bad_cmd) begin
              r_job_err <= 2'd1;
            end else begin
              r_tp_op_code <= r_job.op;
              r_tp_tile_i  <= r_job.i0;
              r_tp_tile_j  <= r_job.j0;
            end
          end
          S_ISSUE: r_tmo_cnt <= '0;
          S_WAIT: begin
            if (!w_done_edge) begin
              if (w_timeout) r_job_err <= 2'd2;
              else           r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end
          S_NEXT: begin
            r_tiles_done <= r_tiles_done + 7'd1;
            if (w_last_tile) begin
              r_job_err <= 2'd0;
            end else if (r_tp_tile_j == r_job.j1) begin
              r_tp_tile_i <= r_tp_tile_i + 3'd1;
              r_tp_tile_j <= r_job.j0;
            end else begin
              r_tp_tile_j <= r_tp_tile_j + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] r_perf_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_busy <= '0;
    end else if (r_busy && (r_perf_busy != '1)) begin
      r_perf_busy <= r_perf_busy + 32'd1;
    end
  end

  assign bus.perf_busy_cycles = r_perf_busy;
`else
  assign bus.perf_busy_cycles = '0;
`endif

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.tp_start   = r_tp_start;
  assign bus.tp_op_code = r_tp_op_code;
  assign bus.tp_tile_i  = r_tp_tile_i;
  assign bus.tp_tile_j  = r_tp_tile_j;
  assign bus.busy       = r_busy;
  assign bus.job_done   = r_job_done;
  assign bus.job_err    = r_job_err;
  assign bus.tiles_done = r_tiles_done;
endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
Job-level sequencer in front of the 8x8-tile processor. Accepts rectangular tile-range commands through a small command FIFO. Walks each range row-major, issuing one start per tile to the tile processor and waiting for its completion. Reports per-job completion or error to the host controller.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT_CYC, 4096, max cycles to wait for tile completion before error
CNT_W, 13, width of timeout counter (must hold TIMEOUT_CYC)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO can accept (= not full)
cmd_op  in  3  op code (0 MUL, 1 ADD, 2 SUB, 3 CONV, 4 DOT)
cmd_i0, cmd_j0  in  3 each  first tile (row, col)
cmd_i1, cmd_j1  in  3 each  last tile, inclusive
abort  in  1  flush queue and current job
tp_start  out  1  one-cycle start pulse to tile processor
tp_op_code  out  3  op for current tile
tp_tile_i, tp_tile_j  out  3 each  current tile coordinates
tp_done  in  1  tile processor done (level; may stay high)
busy  out  1  state != IDLE or FIFO non-empty
job_done  out  1  one-cycle pulse at end of each job
job_err  out  2  valid with job_done: 0 ok, 1 bad command, 2 timeout
tiles_done  out  7  tiles completed in current/last job (0..64)
perf_busy_cycles  out  32  see Optional Feature

Behaviour:
- Reset (rst_n=0 at posedge) values: state IDLE; FIFO empty; cmd_ready=1; tp_start=0; tp_op_code=0; tp_tile_i=0; tp_tile_j=0; job_done=0; job_err=0; tiles_done=0; busy=0; perf_busy_cycles=0. Reset mid-job drops the job with no job_done.
- FIFO:
  - Push on cmd_valid & cmd_ready. cmd_ready = (count != CMD_DEPTH), registered from count.
  - When full, a push is refused that cycle, even if a pop occurs in the same cycle.
  - Pop and push in the same cycle when non-full are both honoured.
  - Order is strictly FIFO.
- tp_done is edge-detected: a tile completes only on a 0->1 transition observed in WAIT. A high level or edges outside WAIT are ignored.
- FSM, all outputs registered:
  - IDLE: FIFO non-empty -> pop into job regs, tiles_done<=0 -> CHECK.
  - CHECK: cmd_op>4 or i1<i0 or j1<j0 -> REPORT with err=1. Otherwise set tp_tile_i=i0, tp_tile_j=j0, tp_op_code=op -> ISSUE.
  - ISSUE: tp_start=1 for exactly this cycle, timeout counter<=0 -> WAIT.
  - WAIT: done edge -> NEXT. Counter reaching TIMEOUT_CYC-1 without edge -> REPORT with err=2. Otherwise counter++.
  - NEXT: tiles_done++.
    - If (tile_i,tile_j)==(i1,j1) -> REPORT err=0.
    - Else if tile_j==j1 -> tile_i++, tile_j=j0 -> ISSUE.
    - Else tile_j++ -> ISSUE.
  - REPORT: job_done=1 one cycle with job_err -> IDLE.
- tp_tile_i/j/op are stable from ISSUE through WAIT of each tile.
- Latency: command pushed at edge N into an idle, empty block -> tp_start high in cycle N+3 (IDLE, CHECK, ISSUE). Done edge at cycle M -> next tp_start at M+2.
- Full-grid job (0,0)-(7,7): 64 tiles, tiles_done=64 at job_done; no coordinate wrap.
- abort (sampled at posedge, priority over all but reset):
  - FIFO emptied, state->IDLE next cycle, no job_done, tp_start=0.
  - tiles_done holds its value.
  - cmd_valid in the abort cycle is discarded.
- job_err holds its value until the next job_done.

Optional Feature:
TILE_SCHED_PERF_EN
- Defined: perf_busy_cycles increments (saturating at 2^32-1) every cycle busy=1. It clears only on reset.
- Undefined: perf_busy_cycles tied to 0, no counter logic. Port is always present.

Test Plan:
- Push op=1,(2,3)-(2,3); bench pulses tp_done 5 cycles after tp_start -> one tp_start with tile (2,3) op 1; job_done, job_err=0, tiles_done=1.
- Push op=0,(0,0)-(1,2) -> tp_start sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); tiles_done=6; exactly one job_done.
- Push op=5 then op=2,(0,0)-(0,0) -> first job_done err=1 with no tp_start; second job completes err=0.
- Bench never raises tp_done, TIMEOUT_CYC=16 -> job_done err=2 exactly 16 cycles after WAIT entry; next queued job proceeds.
- Fill FIFO with 4 commands while first job is stalled -> cmd_ready=0, 5th cmd_valid not accepted. Assert abort -> busy=0 next cycle, no job_done, cmd_ready=1.
- tp_done held high across jobs -> each tile advances only after a 0->1 edge. With TILE_SCHED_PERF_EN, perf_busy_cycles equals the count of busy cycles.
